// File: rtl/cpu_fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
package cpu_fetch_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      LOAD = 2'd2,
      ERR  = 2'd3
   } fetch_state_t;

   localparam logic [1:0] ALIGN_MASK      = 2'b11;
   localparam int         DEFAULT_TIMEOUT = 15;

   // A fetch address is legal only when it is word aligned.
   function automatic logic is_misaligned(input logic [31:0] addr);
      return (addr[1:0] & ALIGN_MASK) != 2'b00;
   endfunction

endpackage

// File: rtl/ifetch_unit.sv
// Fetch sequencer: reads one instruction word per request and strobes it into
// the IR; outputs change only on rising edges so the IR's falling-edge latch sees stable data.
module ifetch_unit
   import cpu_fetch_pkg::*;
#(
   parameter int TIMEOUT = DEFAULT_TIMEOUT,
   parameter int CNT_W   = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        fetch_req,
   input  logic [31:0] pc_in,
   input  logic        flush,
   output logic        imem_rd,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   input  logic        imem_ready,
   output logic        ir_in,
   output logic [31:0] ir_wdata,
   output logic        fetch_done,
   output logic        busy,
   output logic        fault,
   output logic [31:0] fault_addr
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   fetch_state_t     state_r;
   logic [31:0]      addr_r;
   logic [31:0]      data_r;
   logic [31:0]      fault_addr_r;
   logic [CNT_W-1:0] cnt_r;

   // Fetch state machine, address/data capture and timeout counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r      <= IDLE;
         addr_r       <= 32'h0000_0000;
         data_r       <= 32'h0000_0000;
         fault_addr_r <= 32'h0000_0000;
         cnt_r        <= '0;
      end else begin
         case (state_r)
            IDLE: begin
               if (!flush && fetch_req) begin
                  addr_r <= pc_in;
                  cnt_r  <= '0;
                  if (is_misaligned(pc_in)) begin
                     state_r      <= ERR;
                     fault_addr_r <= pc_in;
                  end else begin
                     state_r <= REQ;
                  end
               end
            end
            REQ: begin
               if (flush) begin
                  state_r <= IDLE;
               end else if (imem_ready) begin
                  data_r  <= imem_rdata;
                  state_r <= LOAD;
               end else if ((TIMEOUT != 0) && (cnt_r == CNT_LAST)) begin
                  state_r      <= ERR;
                  fault_addr_r <= addr_r;
               end else begin
                  cnt_r <= cnt_r + CNT_W'(1);
               end
            end
            LOAD: state_r <= IDLE;
            // The fault is sticky until a flush; fault_addr_r is kept.
            ERR: begin
               if (flush) begin
                  state_r <= IDLE;
               end
            end
            default: state_r <= IDLE;
         endcase
      end
   end

   // Outputs decode the registered state; only the LOAD strobe is gated by flush.
   assign imem_rd    = (state_r == REQ);
   assign imem_addr  = addr_r;
   assign ir_in      = (state_r == LOAD) && !flush;
   assign fetch_done = ir_in;
   assign ir_wdata   = data_r;
   assign busy       = (state_r != IDLE);
   assign fault      = (state_r == ERR);
   assign fault_addr = fault_addr_r;

endmodule

// File: tb/tb_ifetch_unit.sv
// Randomised scoreboard bench for ifetch_unit: the driver predicts each fetch's
// outcome (IR load or fault, and the cycle it appears) and a monitor checks it.
module tb_ifetch_unit;

   localparam int TO = 15;

   logic        clk = 1'b0;
   logic        rst;
   logic        fetch_req;
   logic [31:0] pc_in;
   logic        flush;
   logic        imem_rd;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        imem_ready;
   logic        ir_in;
   logic [31:0] ir_wdata;
   logic        fetch_done;
   logic        busy;
   logic        fault;
   logic [31:0] fault_addr;

   ifetch_unit #(.TIMEOUT(TO), .CNT_W(4)) dut (
      .clk(clk), .rst(rst), .fetch_req(fetch_req), .pc_in(pc_in), .flush(flush),
      .imem_rd(imem_rd), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
      .imem_ready(imem_ready), .ir_in(ir_in), .ir_wdata(ir_wdata),
      .fetch_done(fetch_done), .busy(busy), .fault(fault), .fault_addr(fault_addr)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          is_fault;
      logic [31:0] val;
      int          cyc;
   } exp_t;

   exp_t        exp_q[$];
   int          n_tests = 0;
   int          n_fail  = 0;
   int          cyc     = 0;
   logic [31:0] last_word = 32'h0;
   logic [31:0] cur_addr  = 32'h0;
   bit          fault_seen = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic check_event(input bit is_fault, input logic [31:0] val);
      exp_t e;
      if (exp_q.size() == 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL unexpected_event: got %s %h expected none (cycle %0d)",
                  is_fault ? "fault" : "load", val, cyc);
      end else begin
         e = exp_q.pop_front();
         chk("event_kind", {31'h0, is_fault}, {31'h0, e.is_fault});
         chk("event_value", val, e.val);
         chk("event_cycle", cyc, e.cyc);
      end
   endtask

   // Monitor: compares every IR strobe and every fault onset against the queue.
   always @(negedge clk) begin
      if (rst) begin
         fault_seen = 1'b0;
      end else begin
         chk("fetch_done_eq_ir_in", {31'h0, fetch_done}, {31'h0, ir_in});
         if (ir_in === 1'b1) check_event(1'b0, ir_wdata);
         if (fault === 1'b1 && !fault_seen) check_event(1'b1, fault_addr);
         fault_seen = (fault === 1'b1);
         if (imem_rd === 1'b1) chk("imem_addr", imem_addr, cur_addr);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One fetch: a is the PC, w the wait states before imem_ready, d the word,
   // fl_at the REQ cycle carrying a flush (-1 none), fl_load flushes the LOAD cycle.
   task automatic do_fetch(input logic [31:0] a, input int w, input logic [31:0] d,
                           input int fl_at, input bit fl_load);
      exp_t e;
      bit   done;
      int   t0;
      fetch_req = 1'b1;
      pc_in     = a;
      t0        = cyc;
      cur_addr  = a;
      if (a[1:0] != 2'b00) begin
         e = '{1'b1, a, t0 + 1};
         exp_q.push_back(e);
      end else if (fl_at >= 0 && fl_at <= w && fl_at < TO) begin
         // flushed in REQ: nothing reaches the IR
      end else if (w >= TO) begin
         e = '{1'b1, a, t0 + 1 + TO};
         exp_q.push_back(e);
      end else begin
         last_word = d;
         if (!fl_load) begin
            e = '{1'b0, d, t0 + 2 + w};
            exp_q.push_back(e);
         end
      end
      step();
      fetch_req = 1'b0;
      pc_in     = $urandom;
      if (a[1:0] != 2'b00) begin
         step();
         step();
         flush = 1'b1;
         step();
         flush = 1'b0;
      end else begin
         done = 1'b0;
         for (int k = 0; k < TO && !done; k++) begin
            if (k == fl_at) begin
               flush      = 1'b1;
               imem_ready = 1'($urandom_range(1, 0));
               imem_rdata = $urandom;
               step();
               flush      = 1'b0;
               imem_ready = 1'b0;
               done       = 1'b1;
            end else if (k == w) begin
               imem_ready = 1'b1;
               imem_rdata = d;
               step();
               imem_ready = 1'b0;
               imem_rdata = $urandom;
               flush      = fl_load;
               step();
               flush      = 1'b0;
               done       = 1'b1;
            end else begin
               step();
            end
         end
         if (!done) begin
            imem_ready = 1'b1;
            imem_rdata = $urandom;
            step();
            imem_ready = 1'b0;
            flush      = 1'b1;
            step();
            flush      = 1'b0;
         end
      end
      chk("idle_busy", {31'h0, busy}, 32'h0);
      chk("idle_fault", {31'h0, fault}, 32'h0);
      chk("ir_wdata_hold", ir_wdata, last_word);
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_imem_rd"}, {31'h0, imem_rd}, 32'h0);
      chk({tag, "_imem_addr"}, imem_addr, 32'h0);
      chk({tag, "_ir_in"}, {31'h0, ir_in}, 32'h0);
      chk({tag, "_ir_wdata"}, ir_wdata, 32'h0);
      chk({tag, "_fetch_done"}, {31'h0, fetch_done}, 32'h0);
      chk({tag, "_busy"}, {31'h0, busy}, 32'h0);
      chk({tag, "_fault"}, {31'h0, fault}, 32'h0);
      chk({tag, "_fault_addr"}, fault_addr, 32'h0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] a;
      int          w;
      int          fa;
      rst        = 1'b1;
      fetch_req  = 1'b0;
      pc_in      = 32'h0;
      flush      = 1'b0;
      imem_rdata = 32'h0;
      imem_ready = 1'b0;
      #12;
      check_all_zero("reset");
      @(negedge clk);
      rst = 1'b0;
      step();

      do_fetch(32'h0040_0000, 0, 32'h3C01_1001, -1, 1'b0);
      do_fetch(32'h0040_0004, 3, 32'h8C22_0004, -1, 1'b0);
      do_fetch(32'h0040_0006, 0, 32'h0, -1, 1'b0);
      do_fetch(32'h0040_0008, 0, 32'h1234_5678, -1, 1'b0);
      do_fetch(32'h0040_0010, 20, 32'h0, -1, 1'b0);
      chk("fault_addr_keep", fault_addr, 32'h0040_0010);
      do_fetch(32'h0040_0014, 4, 32'hDEAD_BEEF, 2, 1'b0);
      do_fetch(32'h0040_0018, 1, 32'hCAFE_F00D, -1, 1'b1);
      do_fetch(32'h0040_001C, 0, 32'h0BAD_CAFE, 0, 1'b0);

      // flush and fetch_req together in IDLE: the request is dropped
      fetch_req = 1'b1;
      flush     = 1'b1;
      pc_in     = 32'h0040_0020;
      step();
      fetch_req = 1'b0;
      flush     = 1'b0;
      chk("flush_wins_busy", {31'h0, busy}, 32'h0);
      chk("flush_wins_rd", {31'h0, imem_rd}, 32'h0);

      // asynchronous reset in the middle of a REQ
      fetch_req = 1'b1;
      pc_in     = 32'h0040_0024;
      cur_addr  = 32'h0040_0024;
      step();
      fetch_req = 1'b0;
      #3;
      rst = 1'b1;
      #1;
      check_all_zero("async_rst");
      last_word = 32'h0;
      @(negedge clk);
      rst = 1'b0;
      step();
      do_fetch(32'h0040_0028, 2, 32'h2402_000A, -1, 1'b0);

      for (int i = 0; i < 150; i++) begin
         a = $urandom;
         a[1:0] = ($urandom_range(9, 0) == 0) ? 2'($urandom_range(3, 1)) : 2'b00;
         case ($urandom_range(9, 0))
            0:       w = $urandom_range(17, 15);
            1, 2:    w = $urandom_range(10, 5);
            default: w = $urandom_range(4, 0);
         endcase
         fa = ($urandom_range(6, 0) == 0) ? $urandom_range(w, 0) : -1;
         do_fetch(a, w, $urandom, fa, ($urandom_range(9, 0) == 0));
      end

      repeat (3) step();
      chk("scoreboard_drained", exp_q.size(), 32'h0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/ifetch_unit.md
Name: ifetch_unit

Overview:
Instruction fetch sequencer that drives the multicycle CPU's instruction register: it takes a fetch request and PC from the control FSM, reads instruction memory with a ready handshake, then presents the word and a one-cycle write strobe (ir_in) to the IR. The IR latches on the falling clock edge; this block changes its outputs only on rising edges, so data and strobe are stable across that falling edge. It also detects misaligned PCs, memory timeouts and pipeline flushes.

Parameters:
TIMEOUT, 15, maximum REQ-state cycles without imem_ready before a fault; 0 disables the timeout.
CNT_W, 4, timeout counter width; must satisfy 2^CNT_W > TIMEOUT.

Ports:
clk  input  1  system clock; all state changes on the rising edge.
rst  input  1  asynchronous reset, active-high.
fetch_req  input  1  control FSM requests one fetch; sampled only in IDLE.
pc_in  input  32  fetch address, sampled with fetch_req.
flush  input  1  abort the current fetch and clear any fault.
imem_rd  output  1  instruction memory read request.
imem_addr  output  32  registered fetch address.
imem_rdata  input  32  memory read data, valid when imem_ready=1.
imem_ready  input  1  memory read-data-valid; ignored when imem_rd=0.
ir_in  output  1  IR write strobe, exactly one cycle per successful fetch.
ir_wdata  output  32  registered instruction word to IR.
fetch_done  output  1  pulse coincident with ir_in.
busy  output  1  high in any state except IDLE.
fault  output  1  sticky error flag.
fault_addr  output  32  address that caused the fault.

Behaviour:
- Reset (asynchronous, any state): state=IDLE; all outputs, addr_q, data_q and cnt = 0.
- IDLE: if flush=1, stay. Otherwise, if fetch_req=1, addr_q<=pc_in and cnt<=0. If pc_in[1:0]!=0, go to ERR and set fault_addr<=pc_in; else go to REQ. fetch_req while busy is ignored and is not queued.
- REQ: imem_rd=1 and imem_addr=addr_q, held until accepted.
  - If imem_ready=1: data_q<=imem_rdata and go to LOAD.
  - Else if TIMEOUT!=0 and cnt==TIMEOUT-1: go to ERR and set fault_addr<=addr_q.
  - Else cnt<=cnt+1.
  - flush=1 has priority: go to IDLE, with no data capture and no fault.
- LOAD: ir_in = fetch_done = (state==LOAD) && !flush; ir_wdata=data_q. Always go to IDLE next. A flush in this cycle suppresses the strobe.
- ERR: fault=1 and imem_rd=0; ir_in is never asserted. Stay in ERR until flush=1 (go to IDLE and clear fault; fault_addr keeps its value) or rst.
- ir_wdata holds the last successfully loaded word between fetches; it changes only on entry to LOAD.
- Latency: with a zero-wait memory (imem_ready high in the first REQ cycle), fetch_req in cycle 0 produces imem_rd in cycle 1 and ir_in in cycle 2. Each wait state adds one cycle.
- Back-to-back: fetch_req may be high in the cycle after LOAD, giving a sustained rate of 1 fetch per 3 cycles at zero wait.
- Simultaneous flush and fetch_req in IDLE: flush wins and the request is dropped.
- The counter saturates logically, because it is only compared in REQ.

Decomposition:
- Shared package cpu_fetch_pkg:
  - fetch state enum {IDLE, REQ, LOAD, ERR}, 2-bit encoding.
  - ALIGN_MASK = 2'b11.
  - Default TIMEOUT constant.
- Single module. The timeout counter is inline; no sub-module is warranted.

Test Plan:
1. Zero-wait fetch: pc_in=0x00400000 with fetch_req for 1 cycle, imem_ready=1 with rdata=0x3C011001 -> imem_rd high in cycle 1 only; ir_in and fetch_done high in cycle 2 only; ir_wdata=0x3C011001 at that falling edge; busy low in cycle 3.
2. Wait states: imem_ready asserted 3 cycles after imem_rd (rdata=0x8C220004) -> imem_rd high for 4 cycles; ir_in 5 cycles after fetch_req; no fault.
3. Misaligned: pc_in=0x00400006 -> state ERR; fault=1; fault_addr=0x00400006; no imem_rd and no ir_in. Then flush -> fault=0, IDLE, and the next aligned fetch succeeds.
4. Timeout: TIMEOUT=15, imem_ready held low -> fault rises after 15 REQ cycles; fault_addr=pc; ir_in never asserted; a late imem_ready is ignored.
5. Flush: flush during REQ -> IDLE next cycle with ir_wdata unchanged. Flush during LOAD -> ir_in=0 that cycle.
6. Async reset mid-REQ: rst asserted between clock edges -> imem_rd, busy and ir_in drop immediately; ir_wdata=0; after release, fetch_req restarts normally.
